disp_config_sequencer: RTL and testbench



---
 rtl/disp_config_sequencer_pkg.sv | 44 ++++
 rtl/disp_config_sequencer_if.sv | 40 ++++
 rtl/disp_config_sequencer_frame_flasher.sv | 39 +++
 rtl/disp_config_sequencer.sv | 140 ++++++++++++++
 tb/tb_disp_config_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_config_sequencer_pkg.sv
// ============================================================================
// Package   : disp_cfg_pkg
// Purpose   : Shared constants for the display configuration sequencer:
//             mode encoding, reset values and colour width.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_cfg_pkg;

  // Colour depth of one packed RGB attribute (3 bits per channel)
  localparam int RGB_W = 9;

  typedef logic [RGB_W-1:0] rgb_t;

  // Edit-mode encoding; the mode register is exported directly as modeSel
  localparam logic [1:0] M_CHAR_RGB = 2'd0;
  localparam logic [1:0] M_BK_RGB   = 2'd1;
  localparam logic [1:0] M_SIZE     = 2'd2;
  localparam logic [1:0] M_OFFSET   = 2'd3;

  // Power-on values: white characters on a black background
  localparam rgb_t       CHAR_RGB_RST = 9'h1FF;
  localparam rgb_t       BK_RGB_RST   = 9'h000;
  localparam logic [3:0] OFFSET_MAX   = 4'd15;

  // Saturating +/-1 step of a 4-bit value inside [lo, hi]
  function automatic logic [3:0] sat_step(input logic [3:0] val,
                                          input logic       up,
                                          input logic       down,
                                          input logic [3:0] lo,
                                          input logic [3:0] hi);
    logic [3:0] res;
    res = val;
    if (up && (val < hi))
      res = val + 4'd1;
    else if (down && (val > lo))
      res = val - 4'd1;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_config_sequencer_if.sv
// ============================================================================
// Interface : disp_config_sequencer_if
// Purpose   : User-control, sync and committed-attribute signals of the
//             display configuration sequencer.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface disp_config_sequencer_if;
  import disp_cfg_pkg::*;

  logic       vSync;
  logic       btnNext;
  logic       btnUp;
  logic       btnDown;
  rgb_t       charRgbDepth;
  rgb_t       bkRgbDepth;
  logic [3:0] charSize;
  logic [3:0] charOffset;
  logic       flashClk;
  logic [1:0] modeSel;
  logic       pending;

  // Driver side: user controls and sync source
  modport master (
    output vSync, btnNext, btnUp, btnDown,
    input  charRgbDepth, bkRgbDepth, charSize, charOffset,
    input  flashClk, modeSel, pending
  );

  // Sequencer side
  modport slave (
    input  vSync, btnNext, btnUp, btnDown,
    output charRgbDepth, bkRgbDepth, charSize, charOffset,
    output flashClk, modeSel, pending
  );

endinterface

`default_nettype wire

// File: rtl/disp_config_sequencer_frame_flasher.sv
// ============================================================================
// Module    : frame_flasher
// Purpose   : Frame-locked blink clock. Counts frame starts and toggles
//             flashClk every FLASH_FRAMES frames.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_flasher #(
  parameter int FLASH_FRAMES = 30
) (
  input  wire  clock,
  input  wire  reset,
  input  wire  frameEdge,
  output logic flashClk
);

  localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);

  logic [7:0] frame_cnt;

  // Modulo-FLASH_FRAMES frame counter; the toggle shares the wrap edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= 8'd0;
      flashClk  <= 1'b0;
    end else if (frameEdge) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt <= 8'd0;
        flashClk  <= ~flashClk;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_config_sequencer.sv
// ============================================================================
// Module    : disp_config_sequencer
// Purpose   : Frame-synchronous configuration sequencer. Edits one display
//             attribute at a time in shadow registers and commits all of
//             them together at the start of vertical sync.
// Options   : DISP_CFG_FLASH_EN - build the frame-locked blink counter;
//             when undefined flashClk is tied to 1.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_config_sequencer
  import disp_cfg_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int SIZE_MIN     = 1,
  parameter int SIZE_MAX     = 8
) (
  input wire                        clock,
  input wire                        reset,
  disp_config_sequencer_if.slave    bus
);

  localparam logic [3:0] SZ_MIN = 4'(SIZE_MIN);
  localparam logic [3:0] SZ_MAX = 4'(SIZE_MAX);

  // Reject illegal parameterisations at elaboration
  if ((SIZE_MIN > SIZE_MAX) || (SIZE_MAX > 15) || (SIZE_MIN < 0)) begin : g_bad_size
    $error("disp_config_sequencer: illegal SIZE_MIN/SIZE_MAX");
  end
  if ((FLASH_FRAMES < 1) || (FLASH_FRAMES > 255)) begin : g_bad_flash
    $error("disp_config_sequencer: FLASH_FRAMES out of range");
  end

  logic       vsync_q;
  logic       frame_edge;
  logic       edit_up;
  logic       edit_down;
  logic [1:0] mode;

  rgb_t       char_rgb_sh;
  rgb_t       bk_rgb_sh;
  logic [3:0] size_sh;
  logic [3:0] offset_sh;

  rgb_t       char_rgb_q;
  rgb_t       bk_rgb_q;
  logic [3:0] size_q;
  logic [3:0] offset_q;

  // Contradictory up+down presses cancel each other
  assign edit_up    = bus.btnUp & ~bus.btnDown;
  assign edit_down  = bus.btnDown & ~bus.btnUp;

  // Frame start is the first cycle that sees vSync low after it was high
  assign frame_edge = vsync_q & ~bus.vSync;

  // Delay vSync one cycle for falling-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      vsync_q <= 1'b1;
    else
      vsync_q <= bus.vSync;
  end

  // Edit-mode state: btnNext cycles through the four attributes
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      mode <= M_CHAR_RGB;
    else if (bus.btnNext)
      mode <= mode + 2'd1;
  end

  // Shadow edits apply to the mode held before any simultaneous btnNext
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      char_rgb_sh <= CHAR_RGB_RST;
      bk_rgb_sh   <= BK_RGB_RST;
      size_sh     <= SZ_MIN;
      offset_sh   <= 4'd0;
    end else if (edit_up || edit_down) begin
      case (mode)
        M_CHAR_RGB: char_rgb_sh <= edit_up ? char_rgb_sh + rgb_t'(1)
                                           : char_rgb_sh - rgb_t'(1);
        M_BK_RGB:   bk_rgb_sh   <= edit_up ? bk_rgb_sh + rgb_t'(1)
                                           : bk_rgb_sh - rgb_t'(1);
        M_SIZE:     size_sh     <= sat_step(size_sh, edit_up, edit_down,
                                            SZ_MIN, SZ_MAX);
        default:    offset_sh   <= sat_step(offset_sh, edit_up, edit_down,
                                            4'd0, OFFSET_MAX);
      endcase
    end
  end

  // Commit all shadows together; a same-cycle edit lands next frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      char_rgb_q <= CHAR_RGB_RST;
      bk_rgb_q   <= BK_RGB_RST;
      size_q     <= SZ_MIN;
      offset_q   <= 4'd0;
    end else if (frame_edge) begin
      char_rgb_q <= char_rgb_sh;
      bk_rgb_q   <= bk_rgb_sh;
      size_q     <= size_sh;
      offset_q   <= offset_sh;
    end
  end

  assign bus.charRgbDepth = char_rgb_q;
  assign bus.bkRgbDepth   = bk_rgb_q;
  assign bus.charSize     = size_q;
  assign bus.charOffset   = offset_q;
  assign bus.modeSel      = mode;
  assign bus.pending      = (char_rgb_sh != char_rgb_q) |
                            (bk_rgb_sh   != bk_rgb_q)   |
                            (size_sh     != size_q)     |
                            (offset_sh   != offset_q);

`ifdef DISP_CFG_FLASH_EN
  logic flash;

  frame_flasher #(
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_flasher (
    .clock     (clock),
    .reset     (reset),
    .frameEdge (frame_edge),
    .flashClk  (flash)
  );

  assign bus.flashClk = flash;
`else
  // No blinking: characters always visible
  assign bus.flashClk = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_disp_config_sequencer.sv
// ============================================================================
// Module    : tb_disp_config_sequencer
// Purpose   : Directed self-checking bench for disp_config_sequencer.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_config_sequencer;

  logic clock;
  logic reset;
  int   vectors;
  int   errors;

  disp_config_sequencer_if bus();

  disp_config_sequencer #(
    .FLASH_FRAMES (2),
    .SIZE_MIN     (1),
    .SIZE_MAX     (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One button pulse sampled by exactly one rising edge
  task automatic press(input logic n, input logic u, input logic d);
    @(negedge clock);
    bus.btnNext = n;
    bus.btnUp   = u;
    bus.btnDown = d;
    @(negedge clock);
    bus.btnNext = 1'b0;
    bus.btnUp   = 1'b0;
    bus.btnDown = 1'b0;
  endtask

  // One complete vSync low pulse followed by idle high time
  task automatic frame();
    @(negedge clock);
    bus.vSync = 1'b0;
    repeat (3) @(negedge clock);
    bus.vSync = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) frame();
    vectors++;
    if (bus.charRgbDepth !== 9'h1FF || bus.bkRgbDepth !== 9'h000 ||
        bus.charSize !== 4'd1 || bus.charOffset !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h/%0d/%0d want 1ff/000/1/0",
               bus.charRgbDepth, bus.bkRgbDepth, bus.charSize, bus.charOffset);
    end
    vectors++;
    if (bus.pending !== 1'b0 || bus.modeSel !== 2'd0) begin
      errors++;
      $display("FAIL reset_status: pending=%b modeSel=%0d want 0/0",
               bus.pending, bus.modeSel);
    end
  endtask

  task automatic test_char_rgb();
    press(1'b0, 1'b1, 1'b0);  // shadow 1FF -> 000
    vectors++;
    if (bus.pending !== 1'b1 || bus.charRgbDepth !== 9'h1FF) begin
      errors++;
      $display("FAIL rgb_edit: pending=%b char=%h want 1/1ff",
               bus.pending, bus.charRgbDepth);
    end
    @(negedge clock);
    bus.vSync = 1'b0;
    vectors++;
    if (bus.charRgbDepth !== 9'h1FF) begin
      errors++;
      $display("FAIL rgb_pre_commit: got %h want 1ff", bus.charRgbDepth);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (bus.charRgbDepth !== 9'h000 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL rgb_commit: char=%h pending=%b want 000/0",
               bus.charRgbDepth, bus.pending);
    end
    // Edit while sync still low: must not commit during this pulse
    press(1'b0, 1'b1, 1'b0);
    @(negedge clock);
    vectors++;
    if (bus.charRgbDepth !== 9'h000 || bus.pending !== 1'b1) begin
      errors++;
      $display("FAIL rgb_mid_sync: char=%h pending=%b want 000/1",
               bus.charRgbDepth, bus.pending);
    end
    bus.vSync = 1'b1;
    repeat (2) @(negedge clock);
    frame();
    vectors++;
    if (bus.charRgbDepth !== 9'h001 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL rgb_next_frame: char=%h pending=%b want 001/0",
               bus.charRgbDepth, bus.pending);
    end
  endtask

  task automatic test_size();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) press(1'b0, 1'b1, 1'b0);
    frame();
    vectors++;
    if (bus.modeSel !== 2'd2 || bus.charSize !== 4'd8) begin
      errors++;
      $display("FAIL size_max: mode=%0d size=%0d want 2/8",
               bus.modeSel, bus.charSize);
    end
    for (int i = 0; i < 10; i++) press(1'b0, 1'b0, 1'b1);
    frame();
    vectors++;
    if (bus.charSize !== 4'd1 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL size_min: size=%0d pending=%b want 1/0",
               bus.charSize, bus.pending);
    end
  endtask

  task automatic test_edge_edit();
    press(1'b1, 1'b0, 1'b0);  // mode 3, offset 0
    @(negedge clock);
    bus.btnUp = 1'b1;
    bus.vSync = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if (bus.charOffset !== 4'd0 || bus.pending !== 1'b1 || bus.modeSel !== 2'd3) begin
      errors++;
      $display("FAIL edge_edit: off=%0d pending=%b mode=%0d want 0/1/3",
               bus.charOffset, bus.pending, bus.modeSel);
    end
    @(negedge clock);
    bus.btnUp = 1'b0;
    repeat (2) @(negedge clock);
    bus.vSync = 1'b1;
    repeat (2) @(negedge clock);
    frame();
    vectors++;
    if (bus.charOffset !== 4'd1 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL edge_edit_late: off=%0d pending=%b want 1/0",
               bus.charOffset, bus.pending);
    end
  endtask

  task automatic test_both_next();
    press(1'b0, 1'b1, 1'b1);
    vectors++;
    if (bus.pending !== 1'b0 || bus.modeSel !== 2'd3) begin
      errors++;
      $display("FAIL up_down_cancel: pending=%b mode=%0d want 0/3",
               bus.pending, bus.modeSel);
    end
    press(1'b1, 1'b1, 1'b0);
    vectors++;
    if (bus.pending !== 1'b1 || bus.modeSel !== 2'd0) begin
      errors++;
      $display("FAIL next_with_edit: pending=%b mode=%0d want 1/0",
               bus.pending, bus.modeSel);
    end
    frame();
    vectors++;
    if (bus.charOffset !== 4'd2 || bus.charRgbDepth !== 9'h001) begin
      errors++;
      $display("FAIL next_commit: off=%0d char=%h want 2/001",
               bus.charOffset, bus.charRgbDepth);
    end
  endtask

  task automatic test_rgb_wrap();
    press(1'b0, 1'b0, 1'b1);  // 001 -> 000
    press(1'b0, 1'b0, 1'b1);  // 000 -> 1FF
    press(1'b1, 1'b0, 1'b0);  // mode 1
    press(1'b0, 1'b0, 1'b1);  // bk 000 -> 1FF
    frame();
    vectors++;
    if (bus.charRgbDepth !== 9'h1FF || bus.bkRgbDepth !== 9'h1FF || bus.modeSel !== 2'd1) begin
      errors++;
      $display("FAIL rgb_wrap: char=%h bk=%h mode=%0d want 1ff/1ff/1",
               bus.charRgbDepth, bus.bkRgbDepth, bus.modeSel);
    end
  endtask

  task automatic test_reset_mid_edit();
    press(1'b0, 1'b1, 1'b0);  // bk shadow 1FF -> 000
    vectors++;
    if (bus.pending !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pending: got %b want 1", bus.pending);
    end
    do_reset();
    vectors++;
    if (bus.bkRgbDepth !== 9'h000 || bus.charRgbDepth !== 9'h1FF ||
        bus.charOffset !== 4'd0 || bus.pending !== 1'b0 || bus.modeSel !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_edit: bk=%h char=%h off=%0d pending=%b mode=%0d want 000/1ff/0/0/0",
               bus.bkRgbDepth, bus.charRgbDepth, bus.charOffset, bus.pending, bus.modeSel);
    end
    frame();
    vectors++;
    if (bus.bkRgbDepth !== 9'h000 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: bk=%h pending=%b want 000/0",
               bus.bkRgbDepth, bus.pending);
    end
  endtask

  task automatic test_flash();
    logic exp;
    do_reset();
`ifdef DISP_CFG_FLASH_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    vectors++;
    if (bus.flashClk !== exp) begin
      errors++;
      $display("FAIL flash_reset: got %b want %b", bus.flashClk, exp);
    end
    for (int k = 1; k <= 8; k++) begin
      frame();
`ifdef DISP_CFG_FLASH_EN
      // Toggles on frames 2,4,6,8 with FLASH_FRAMES=2
      exp = ((k / 2) % 2) == 1;
`else
      exp = 1'b1;
`endif
      vectors++;
      if (bus.flashClk !== exp) begin
        errors++;
        $display("FAIL flash_frame%0d: got %b want %b", k, bus.flashClk, exp);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.vSync   = 1'b1;
    bus.btnNext = 1'b0;
    bus.btnUp   = 1'b0;
    bus.btnDown = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_char_rgb();
    test_size();
    test_edge_edit();
    test_both_next();
    test_rgb_wrap();
    test_reset_mid_edit();
    test_flash();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
